// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared types and constants for the SM83 interrupt controller
package sm83_pkg;

  typedef enum logic [2:0] {
    D_IDLE,
    D_NOP,
    D_SPDEC,
    D_PUSH_HI,
    D_PUSH_LO,
    D_JUMP
  } int_state_t;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [7:0] INT_VEC_BASE   = 8'h40;
  localparam logic [7:0] IF_UNUSED_MASK = 8'hE0;

  // Each source owns an 8-byte slot above the vector base.
  function automatic logic [7:0] irq_vector(input int idx);
    return INT_VEC_BASE + 8'(idx * 8);
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - register bus, request and dispatch strobes of the interrupt controller
interface int_ctrl_if;

  logic [4:0] irq_in;
  logic       reg_we;
  logic       reg_sel;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       instr_boundary;
  logic       ei;
  logic       di;
  logic       reti;
  logic       halted;
  logic       int_req;
  logic       sp_dec;
  logic       push_pc_hi;
  logic       push_pc_lo;
  logic       vec_to_pc;
  logic [7:0] vector;
  logic       wake;
  logic       halt_bug;

  modport slave (
    input  irq_in, reg_we, reg_sel, reg_wdata,
    input  instr_boundary, ei, di, reti, halted,
    output reg_rdata, int_req, sp_dec, push_pc_hi, push_pc_lo,
    output vec_to_pc, vector, wake, halt_bug
  );

  modport master (
    output irq_in, reg_we, reg_sel, reg_wdata,
    output instr_boundary, ei, di, reti, halted,
    input  reg_rdata, int_req, sp_dec, push_pc_hi, push_pc_lo,
    input  vec_to_pc, vector, wake, halt_bug
  );

endinterface

// File: rtl/int_prio.sv
// rtl/int_prio.sv - fixed-priority resolver: lowest pending source wins
module int_prio
  import sm83_pkg::*;
(
  input  logic [4:0] pend,
  output logic       valid,
  output logic [7:0] vector
);

  always_comb begin
    valid  = |pend;
    vector = 8'h00;
    if (pend[IRQ_VBLANK])      vector = irq_vector(IRQ_VBLANK);
    else if (pend[IRQ_STAT])   vector = irq_vector(IRQ_STAT);
    else if (pend[IRQ_TIMER])  vector = irq_vector(IRQ_TIMER);
    else if (pend[IRQ_SERIAL]) vector = irq_vector(IRQ_SERIAL);
    else if (pend[IRQ_JOYPAD]) vector = irq_vector(IRQ_JOYPAD);
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - SM83 IF/IE/IME state, priority and 5-M-cycle dispatch sequencer
// Optional HALT-bug detection is built when SM83_HALT_BUG_EN is defined.
module int_ctrl
  import sm83_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  int_ctrl_if.slave  bus
);

  logic [4:0] if_q;
  logic [7:0] ie_q;
  logic       ime;
  logic       ei_armed;
  int_state_t state;
  logic       sp_dec_q;
  logic       push_hi_q;
  logic       push_lo_q;
  logic       vec_to_pc_q;
  logic [7:0] vector_q;

  logic [4:0] pend;
  logic       prio_valid;
  logic [7:0] prio_vector;
  logic [4:0] clr_mask;
  logic [4:0] if_next;
  logic       int_req;

  assign pend     = ie_q[4:0] & if_q;
  assign clr_mask = pend & (~pend + 5'd1);
  assign int_req  = (state == D_IDLE) & ime & (|pend) & bus.instr_boundary & ~bus.halted;

  int_prio u_prio (
    .pend   (pend),
    .valid  (prio_valid),
    .vector (prio_vector)
  );

  // Write first, then dispatch clear, then new requests so no pulse is dropped.
  always_comb begin
    if_next = if_q;
    if (bus.reg_we && !bus.reg_sel) if_next = bus.reg_wdata[4:0];
    if ((state == D_PUSH_HI) && prio_valid) if_next = if_next & ~clr_mask;
    if_next = if_next | bus.irq_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_q <= 5'h00;
      ie_q <= 8'h00;
    end else begin
      if_q <= if_next;
      if (bus.reg_we && bus.reg_sel) ie_q <= bus.reg_wdata;
    end
  end

  // The armed flag delays IME by one instruction after EI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ime      <= 1'b0;
      ei_armed <= 1'b0;
    end else if (int_req) begin
      ime <= 1'b0;
    end else if (state == D_IDLE) begin
      if (bus.di) begin
        ime      <= 1'b0;
        ei_armed <= 1'b0;
      end else begin
        if (bus.reti) ime <= 1'b1;
        if (ei_armed && bus.instr_boundary) begin
          ime      <= 1'b1;
          ei_armed <= bus.ei;
        end else if (bus.ei) begin
          ei_armed <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= D_IDLE;
      sp_dec_q    <= 1'b0;
      push_hi_q   <= 1'b0;
      push_lo_q   <= 1'b0;
      vec_to_pc_q <= 1'b0;
      vector_q    <= 8'h00;
    end else begin
      sp_dec_q    <= 1'b0;
      push_hi_q   <= 1'b0;
      push_lo_q   <= 1'b0;
      vec_to_pc_q <= 1'b0;
      case (state)
        D_IDLE: begin
          if (int_req) state <= D_NOP;
        end
        D_NOP: begin
          state    <= D_SPDEC;
          sp_dec_q <= 1'b1;
        end
        D_SPDEC: begin
          state     <= D_PUSH_HI;
          push_hi_q <= 1'b1;
          sp_dec_q  <= 1'b1;
        end
        D_PUSH_HI: begin
          // IE may have just been overwritten by the high push; resolve now.
          state     <= D_PUSH_LO;
          push_lo_q <= 1'b1;
          vector_q  <= prio_vector;
        end
        D_PUSH_LO: begin
          state       <= D_JUMP;
          vec_to_pc_q <= 1'b1;
        end
        D_JUMP: begin
          state <= D_IDLE;
        end
        default: begin
          state <= D_IDLE;
        end
      endcase
    end
  end

`ifdef SM83_HALT_BUG_EN
  logic halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= bus.halted;
  end

  assign bus.halt_bug = bus.halted & ~halted_q & ~ime & (|pend);
`else
  assign bus.halt_bug = 1'b0;
`endif

  assign bus.reg_rdata  = bus.reg_sel ? ie_q : (IF_UNUSED_MASK | {3'b000, if_q});
  assign bus.int_req    = int_req;
  assign bus.sp_dec     = sp_dec_q;
  assign bus.push_pc_hi = push_hi_q;
  assign bus.push_pc_lo = push_lo_q;
  assign bus.vec_to_pc  = vec_to_pc_q;
  assign bus.vector     = vector_q;
  assign bus.wake       = |pend;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed vector table plus dispatch sequences for int_ctrl
module tb_int_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SM83_HALT_BUG_EN
  localparam logic HB_EXP = 1'b1;
`else
  localparam logic HB_EXP = 1'b0;
`endif

  typedef struct {
    logic       we;
    logic       sel;
    logic [7:0] wdata;
    logic [4:0] irq;
    logic [7:0] exp_if;
    logic [7:0] exp_ie;
    logic       exp_wake;
  } vec_t;

  vec_t tbl [8];

  logic [3:0] stb;
  assign stb = {bus.sp_dec, bus.push_pc_hi, bus.push_pc_lo, bus.vec_to_pc};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.irq_in         = 5'h00;
    bus.reg_we         = 1'b0;
    bus.reg_sel        = 1'b0;
    bus.reg_wdata      = 8'h00;
    bus.instr_boundary = 1'b0;
    bus.ei             = 1'b0;
    bus.di             = 1'b0;
    bus.reti           = 1'b0;
    bus.halted         = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Leaves the bench one cycle after int_req, i.e. in D_NOP.
  task automatic start_dispatch(input string name, input logic [7:0] ie, input logic [4:0] irq);
    do_reset();
    bus.reg_we = 1'b1; bus.reg_sel = 1'b1; bus.reg_wdata = ie; bus.irq_in = irq;
    tick();
    bus.reg_we = 1'b0; bus.irq_in = 5'h00; bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0; bus.instr_boundary = 1'b1;
    #1;
    check({name, "_int_req"}, 8'(bus.int_req), 8'd1);
    tick();
    bus.instr_boundary = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    clear_inputs();
    rst_n = 1'b0;

    tbl[0] = '{1'b1, 1'b1, 8'h1F, 5'h00, 8'hE0, 8'h1F, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 5'h01, 8'hE1, 8'h1F, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 5'h04, 8'hE4, 8'h1F, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 8'hFF, 5'h00, 8'hFF, 8'h1F, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'h00, 5'h00, 8'hFF, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 8'h0A, 5'h01, 8'hEB, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'h02, 5'h00, 8'hEB, 8'h02, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 8'h10, 5'h00, 8'hF0, 8'h02, 1'b0};

    tick();
    bus.reg_sel = 1'b0; #1;
    check("rst_if", bus.reg_rdata, 8'hE0);
    bus.reg_sel = 1'b1; #1;
    check("rst_ie", bus.reg_rdata, 8'h00);
    check("rst_vector", bus.vector, 8'h00);
    check("rst_strobes", 8'(stb), 8'h0);
    check("rst_int_req", 8'(bus.int_req), 8'd0);
    check("rst_wake", 8'(bus.wake), 8'd0);
    check("rst_halt_bug", 8'(bus.halt_bug), 8'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      bus.reg_we = tbl[i].we; bus.reg_sel = tbl[i].sel;
      bus.reg_wdata = tbl[i].wdata; bus.irq_in = tbl[i].irq;
      tick();
      bus.reg_we = 1'b0; bus.irq_in = 5'h00;
      bus.reg_sel = 1'b0; #1;
      check($sformatf("tbl%0d_if", i), bus.reg_rdata, tbl[i].exp_if);
      bus.reg_sel = 1'b1; #1;
      check($sformatf("tbl%0d_ie", i), bus.reg_rdata, tbl[i].exp_ie);
      check($sformatf("tbl%0d_wake", i), 8'(bus.wake), 8'(tbl[i].exp_wake));
      check($sformatf("tbl%0d_no_req", i), 8'(bus.int_req), 8'd0);
    end

    // Vector selection: STAT beats Timer.
    start_dispatch("vsel", 8'h1F, 5'b00110);
    check("vsel_c1", 8'(stb), 8'h0);
    tick(); check("vsel_c2", 8'(stb), 8'h8);
    tick(); check("vsel_c3", 8'(stb), 8'hC);
    tick(); check("vsel_c4", 8'(stb), 8'h2);
    check("vsel_vec_c4", bus.vector, 8'h48);
    tick(); check("vsel_c5", 8'(stb), 8'h1);
    check("vsel_vec_c5", bus.vector, 8'h48);
    bus.reg_sel = 1'b0; #1;
    check("vsel_if", bus.reg_rdata, 8'hE4);
    tick(); check("vsel_c6", 8'(stb), 8'h0);
    bus.instr_boundary = 1'b1; #1;
    check("vsel_ime_cleared", 8'(bus.int_req), 8'd0);
    bus.instr_boundary = 1'b0;

    // EI delay of one instruction.
    do_reset();
    bus.reg_we = 1'b1; bus.reg_sel = 1'b1; bus.reg_wdata = 8'h04; bus.irq_in = 5'b00100;
    tick();
    bus.reg_we = 1'b0; bus.irq_in = 5'h00;
    bus.ei = 1'b1; bus.instr_boundary = 1'b1; #1;
    check("ei_k", 8'(bus.int_req), 8'd0);
    tick(); bus.ei = 1'b0; #1;
    check("ei_k1", 8'(bus.int_req), 8'd0);
    tick();
    check("ei_k2", 8'(bus.int_req), 8'd1);
    tick(); bus.instr_boundary = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("ei_jump", 8'(stb), 8'h1);
    check("ei_vector", bus.vector, 8'h50);
    tick();
    bus.irq_in = 5'b00100;
    tick(); bus.irq_in = 5'h00;
    bus.ei = 1'b1; bus.di = 1'b1; bus.instr_boundary = 1'b1;
    tick(); bus.ei = 1'b0; bus.di = 1'b0;
    tick(); tick();
    check("di_wins", 8'(bus.int_req), 8'd0);
    bus.instr_boundary = 1'b0;

    // IE cleared by the high push cancels the vector.
    start_dispatch("cancel", 8'h01, 5'b00001);
    tick();
    bus.reg_we = 1'b1; bus.reg_sel = 1'b1; bus.reg_wdata = 8'h00;
    tick(); bus.reg_we = 1'b0;
    tick(); check("cancel_vec", bus.vector, 8'h00);
    tick(); check("cancel_jump", 8'(stb), 8'h1);
    bus.reg_sel = 1'b0; #1;
    check("cancel_if", bus.reg_rdata, 8'hE1);
    tick();

    // New request on the bit being cleared survives.
    start_dispatch("race", 8'h1F, 5'b00001);
    tick(); tick();
    bus.irq_in = 5'b00001;
    tick(); bus.irq_in = 5'h00;
    check("race_vec", bus.vector, 8'h40);
    bus.reg_sel = 1'b0; #1;
    check("race_if", bus.reg_rdata, 8'hE1);
    tick(); tick();

    // HALT wake, halt bug, and halted gating of dispatch.
    do_reset();
    bus.reg_we = 1'b1; bus.reg_sel = 1'b1; bus.reg_wdata = 8'h01;
    tick(); bus.reg_we = 1'b0;
    bus.halted = 1'b1; #1;
    check("hb_nopend", 8'(bus.halt_bug), 8'd0);
    tick();
    check("halt_no_wake", 8'(bus.wake), 8'd0);
    bus.irq_in = 5'b00001;
    tick(); bus.irq_in = 5'h00;
    check("halt_wake", 8'(bus.wake), 8'd1);
    bus.instr_boundary = 1'b1; #1;
    check("halt_ime0_req", 8'(bus.int_req), 8'd0);
    tick();
    check("halt_ime0_stb", 8'(stb), 8'h0);
    bus.instr_boundary = 1'b0;
    bus.halted = 1'b0;
    tick();
    bus.halted = 1'b1; #1;
    check("hb_rise", 8'(bus.halt_bug), 8'(HB_EXP));
    tick();
    check("hb_once", 8'(bus.halt_bug), 8'd0);
    bus.reti = 1'b1;
    tick(); bus.reti = 1'b0;
    bus.instr_boundary = 1'b1; #1;
    check("halted_blocks", 8'(bus.int_req), 8'd0);
    bus.halted = 1'b0; #1;
    check("wake_dispatch", 8'(bus.int_req), 8'd1);
    tick(); bus.instr_boundary = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Asynchronous reset in D_PUSH_LO.
    start_dispatch("rst", 8'h01, 5'b00001);
    tick(); tick(); tick();
    check("pre_rst", 8'(stb), 8'h2);
    rst_n = 1'b0; #1;
    check("rst_async_stb", 8'(stb), 8'h0);
    tick(); rst_n = 1'b1;
    tick();
    bus.reg_sel = 1'b0; #1;
    check("rst_if_clear", bus.reg_rdata, 8'hE0);
    bus.reg_we = 1'b1; bus.reg_sel = 1'b1; bus.reg_wdata = 8'h01; bus.irq_in = 5'b00001;
    tick(); bus.reg_we = 1'b0; bus.irq_in = 5'h00;
    bus.instr_boundary = 1'b1; #1;
    check("rst_ime_clear", 8'(bus.int_req), 8'd0);
    bus.instr_boundary = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
